// File: rtl/cale_de_date_pkg.sv
// Shared definitions for the cale_de_date multiplier/divider pair:
// state encoding and default operand width.
package cale_de_date_pkg;

   localparam int unsigned X_DEF = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/pas_impartire.sv
// One combinational restoring-division step: shift in a dividend bit, then
// subtract the divisor when it fits.
module pas_impartire #(
   parameter int unsigned W = 8
) (
   input  logic [W-1:0] i_rem,
   input  logic         i_bit,
   input  logic [W-1:0] i_div,
   output logic [W-1:0] o_rem,
   output logic         o_q
);

   logic [W:0] w_r;
   logic       w_ge;

   assign w_r  = {i_rem, i_bit};
   assign w_ge = (w_r >= {1'b0, i_div});
   assign o_q  = w_ge;
   // The restored remainder is always below the divisor, so W bits suffice.
   assign o_rem = w_ge ? W'(w_r - {1'b0, i_div}) : w_r[W-1:0];

endmodule

// File: rtl/cale_de_dated.sv
// Sequential restoring divider: 2x-bit dividend / x-bit divisor, one quotient
// bit per cycle, with the load/busy/ready handshake of the multiplier.
module cale_de_dated
   import cale_de_date_pkg::*;
#(
   parameter int unsigned x = X_DEF
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           load,
   input  logic [2*x-1:0] OpA,
   input  logic [x-1:0]   OpB,
   output logic [x-1:0]   cat,
   output logic [x-1:0]   rest,
   output logic           err,
   output logic           busy,
   output logic           ready
);

   localparam int unsigned CW = $clog2(x + 1);

   state_e        r_state;
   state_e        w_state_next;
   // Partial remainder; its (x+1)th bit is always zero between steps.
   logic [x-1:0]  r_rem;
   logic [x-1:0]  r_q;
   logic [x-1:0]  r_div;
   logic [CW-1:0] r_cnt;
   logic [x-1:0]  r_cat;
   logic [x-1:0]  r_rest;
   logic          r_err;

   logic          w_accept;
   logic          w_ovf;
   logic          w_last;
   logic [x-1:0]  w_rem_next;
   logic          w_q_bit;

   assign w_accept = (r_state == IDLE) && load;
   // High half >= divisor covers both divide-by-zero and quotient overflow.
   assign w_ovf    = (OpA[2*x-1:x] >= OpB);
   assign w_last   = (r_state == RUN) && (r_cnt == CW'(1));

   pas_impartire #(
      .W(x)
   ) u_pas (
      .i_rem(r_rem),
      .i_bit(r_q[x-1]),
      .i_div(r_div),
      .o_rem(w_rem_next),
      .o_q  (w_q_bit)
   );

   always_comb begin
      w_state_next = r_state;
      busy         = 1'b0;
      ready        = 1'b0;
      case (r_state)
         IDLE: begin
            if (load) begin
               w_state_next = w_ovf ? DONE : RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (r_cnt == CW'(1)) begin
               w_state_next = DONE;
            end
         end
         DONE: begin
            busy         = 1'b1;
            ready        = 1'b1;
            w_state_next = IDLE;
         end
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_rem  <= '0;
         r_q    <= '0;
         r_div  <= '0;
         r_cnt  <= '0;
         r_cat  <= '0;
         r_rest <= '0;
         r_err  <= 1'b0;
      end else begin
         if (w_accept && !w_ovf) begin
            r_rem <= OpA[2*x-1:x];
            r_q   <= OpA[x-1:0];
            r_div <= OpB;
            r_cnt <= CW'(x);
         end else if (r_state == RUN) begin
            r_rem <= w_rem_next;
            r_q   <= {r_q[x-2:0], w_q_bit};
            r_cnt <= r_cnt - CW'(1);
         end

         if (w_accept && w_ovf) begin
            r_cat  <= '1;
            r_rest <= '0;
            r_err  <= 1'b1;
         end else if (w_last) begin
            r_cat  <= {r_q[x-2:0], w_q_bit};
            r_rest <= w_rem_next;
            r_err  <= 1'b0;
         end
      end
   end

   assign cat  = r_cat;
   assign rest = r_rest;
   assign err  = r_err;

endmodule

// File: tb/tb_cale_de_dated.sv
// Directed bench for cale_de_dated (x=8): latency, error path, ignored load,
// mid-run reset and back-to-back operation.
module tb_cale_de_dated;

   logic        clk = 1'b0;
   logic        reset;
   logic        load;
   logic [15:0] OpA;
   logic [7:0]  OpB;
   logic [7:0]  cat;
   logic [7:0]  rest;
   logic        err;
   logic        busy;
   logic        ready;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   cale_de_dated #(
      .x(8)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .load (load),
      .OpA  (OpA),
      .OpB  (OpB),
      .cat  (cat),
      .rest (rest),
      .err  (err),
      .busy (busy),
      .ready(ready)
   );

   // Leaves the caller #1 after the accepting edge, i.e. inside cycle 1.
   task automatic start_op(input logic [15:0] a, input logic [7:0] b);
      @(negedge clk);
      OpA  = a;
      OpB  = b;
      load = 1'b1;
      @(posedge clk);
      #1;
      load = 1'b0;
   endtask

   // Returns the cycle number (relative to the accepting edge) of ready, or -1.
   task automatic wait_ready(output int cyc);
      cyc = 1;
      while (ready !== 1'b1 && cyc < 40) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      if (ready !== 1'b1) cyc = -1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      load  = 1'b0;
      OpA   = '0;
      OpB   = '0;
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if (cat !== 8'd0) begin n_fail++; $display("FAIL reset_cat: got %0d expected 0", cat); end
      n_checks++;
      if (rest !== 8'd0) begin n_fail++; $display("FAIL reset_rest: got %0d expected 0", rest); end
      n_checks++;
      if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err); end
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
      n_checks++;
      if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", ready); end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_basic();
      int cyc;
      start_op(16'd1000, 8'd7);
      n_checks++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_rise: got %b expected 1", busy); end
      wait_ready(cyc);
      n_checks++;
      if (cyc !== 9) begin n_fail++; $display("FAIL basic_latency: got %0d expected 9", cyc); end
      n_checks++;
      if (cat !== 8'd142) begin n_fail++; $display("FAIL basic_cat: got %0d expected 142", cat); end
      n_checks++;
      if (rest !== 8'd6) begin n_fail++; $display("FAIL basic_rest: got %0d expected 6", rest); end
      n_checks++;
      if (err !== 1'b0) begin n_fail++; $display("FAIL basic_err: got %b expected 0", err); end
      @(posedge clk);
      #1;
      n_checks++;
      if (ready !== 1'b0) begin n_fail++; $display("FAIL basic_ready_pulse: got %b expected 0", ready); end
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_fall: got %b expected 0", busy); end
   endtask

   task automatic test_max();
      int cyc;
      start_op(16'd65025, 8'd255);
      wait_ready(cyc);
      n_checks++;
      if (cyc !== 9) begin n_fail++; $display("FAIL max_latency: got %0d expected 9", cyc); end
      n_checks++;
      if (cat !== 8'd255) begin n_fail++; $display("FAIL max_cat: got %0d expected 255", cat); end
      n_checks++;
      if (rest !== 8'd0) begin n_fail++; $display("FAIL max_rest: got %0d expected 0", rest); end
      n_checks++;
      if (err !== 1'b0) begin n_fail++; $display("FAIL max_err: got %b expected 0", err); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_error();
      int cyc;
      start_op(16'd300, 8'd0);
      wait_ready(cyc);
      n_checks++;
      if (cyc !== 1) begin n_fail++; $display("FAIL div0_latency: got %0d expected 1", cyc); end
      n_checks++;
      if (err !== 1'b1) begin n_fail++; $display("FAIL div0_err: got %b expected 1", err); end
      n_checks++;
      if (cat !== 8'd255) begin n_fail++; $display("FAIL div0_cat: got %0d expected 255", cat); end
      n_checks++;
      if (rest !== 8'd0) begin n_fail++; $display("FAIL div0_rest: got %0d expected 0", rest); end
      @(posedge clk);
      #1;
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL div0_busy_cycle2: got %b expected 0", busy); end
      start_op(16'd65535, 8'd255);
      wait_ready(cyc);
      n_checks++;
      if (cyc !== 1) begin n_fail++; $display("FAIL ovf_latency: got %0d expected 1", cyc); end
      n_checks++;
      if (err !== 1'b1) begin n_fail++; $display("FAIL ovf_err: got %b expected 1", err); end
      n_checks++;
      if (cat !== 8'd255) begin n_fail++; $display("FAIL ovf_cat: got %0d expected 255", cat); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_ignore_load();
      int pulses;
      int first;
      start_op(16'd1000, 8'd7);
      repeat (3) @(posedge clk);
      #1;
      OpA  = 16'd50;
      OpB  = 8'd5;
      load = 1'b1;
      @(posedge clk);
      #1;
      load   = 1'b0;
      pulses = 0;
      first  = -1;
      for (int c = 5; c <= 16; c++) begin
         if (ready === 1'b1) begin
            pulses++;
            if (first < 0) first = c;
         end
         @(posedge clk);
         #1;
      end
      n_checks++;
      if (pulses !== 1) begin n_fail++; $display("FAIL ignore_pulses: got %0d expected 1", pulses); end
      n_checks++;
      if (first !== 9) begin n_fail++; $display("FAIL ignore_latency: got %0d expected 9", first); end
      n_checks++;
      if (cat !== 8'd142) begin n_fail++; $display("FAIL ignore_cat: got %0d expected 142", cat); end
      n_checks++;
      if (rest !== 8'd6) begin n_fail++; $display("FAIL ignore_rest: got %0d expected 6", rest); end
      n_checks++;
      if (err !== 1'b0) begin n_fail++; $display("FAIL ignore_err: got %b expected 0", err); end
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL ignore_idle: got %b expected 0", busy); end
   endtask

   task automatic test_reset_mid();
      int cyc;
      int pulses;
      start_op(16'd1000, 8'd7);
      repeat (4) @(posedge clk);
      #1;
      // Load in the same cycle as reset must lose.
      reset = 1'b1;
      load  = 1'b1;
      OpA   = 16'd300;
      OpB   = 8'd0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      load  = 1'b0;
      n_checks++;
      if (cat !== 8'd0) begin n_fail++; $display("FAIL midrst_cat: got %0d expected 0", cat); end
      n_checks++;
      if (rest !== 8'd0) begin n_fail++; $display("FAIL midrst_rest: got %0d expected 0", rest); end
      n_checks++;
      if (err !== 1'b0) begin n_fail++; $display("FAIL midrst_err: got %b expected 0", err); end
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", busy); end
      n_checks++;
      if (ready !== 1'b0) begin n_fail++; $display("FAIL midrst_ready: got %b expected 0", ready); end
      pulses = 0;
      for (int c = 0; c < 12; c++) begin
         @(posedge clk);
         #1;
         if (ready === 1'b1) pulses++;
      end
      n_checks++;
      if (pulses !== 0) begin n_fail++; $display("FAIL midrst_no_ready: got %0d expected 0", pulses); end
      start_op(16'd81, 8'd9);
      wait_ready(cyc);
      n_checks++;
      if (cyc !== 9) begin n_fail++; $display("FAIL after_rst_latency: got %0d expected 9", cyc); end
      n_checks++;
      if (cat !== 8'd9) begin n_fail++; $display("FAIL after_rst_cat: got %0d expected 9", cat); end
      n_checks++;
      if (rest !== 8'd0) begin n_fail++; $display("FAIL after_rst_rest: got %0d expected 0", rest); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_back_to_back();
      int a[100];
      int b[100];
      int cyc;
      int q;
      int r;
      for (int i = 0; i < 100; i++) begin
         b[i] = int'($urandom_range(1, 255));
         a[i] = int'($urandom_range(0, b[i] * 256 - 1));
      end
      @(negedge clk);
      OpA  = 16'(a[0]);
      OpB  = 8'(b[0]);
      load = 1'b1;
      for (int i = 0; i < 100; i++) begin
         cyc = 0;
         do begin
            @(posedge clk);
            #1;
            cyc++;
         end while (ready !== 1'b1 && cyc < 40);
         n_checks++;
         if (ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_timeout op %0d: got no ready expected ready within 40 cycles", i);
            break;
         end
         q = int'(cat);
         r = int'(rest);
         n_checks++;
         if (cyc !== ((i == 0) ? 9 : 10)) begin
            n_fail++;
            $display("FAIL b2b_spacing op %0d: got %0d expected %0d", i, cyc, (i == 0) ? 9 : 10);
         end
         n_checks++;
         if (q * b[i] + r !== a[i]) begin
            n_fail++;
            $display("FAIL b2b_invariant op %0d: got %0d*%0d+%0d expected %0d", i, q, b[i], r, a[i]);
         end
         n_checks++;
         if (r >= b[i]) begin
            n_fail++;
            $display("FAIL b2b_rest_lt op %0d: got %0d expected below %0d", i, r, b[i]);
         end
         n_checks++;
         if (err !== 1'b0) begin n_fail++; $display("FAIL b2b_err op %0d: got %b expected 0", i, err); end
         @(negedge clk);
         if (i < 99) begin
            OpA = 16'(a[i+1]);
            OpB = 8'(b[i+1]);
         end else begin
            load = 1'b0;
         end
      end
      load = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      load  = 1'b0;
      OpA   = '0;
      OpB   = '0;
      test_reset();
      test_basic();
      test_max();
      test_error();
      test_ignore_load();
      test_reset_mid();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no completion expected finish before 1 ms");
      $fatal(1, "watchdog expired");
   end

endmodule
